streebog_bus_driver: RTL and testbench
======================================

Name: streebog_bus_driver

Overview:
Bus initiator that drives the 8-bit-address/32-bit-data register port of the Streebog hash core.
- Accepts a message as a 32-bit word stream and loads it into the core's BLOCK registers in 512-bit blocks.
- Sequences INIT/UPDATE/FINAL through CTRL and polls STATUS.
- Reads back the digest and streams it out.
- Sits between a DMA/stream fabric and the core, replacing software register sequencing.

Parameters:
POLL_LIMIT, 4096, maximum cycles spent polling STATUS before error abort (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  1-cycle request to hash a new message; ignored while busy
short_mode  in  1  sampled at start; 1 = 256-bit digest
busy  out  1  high from accepted start until done
done  out  1  1-cycle pulse at end of job (success or error)
error  out  1  set with done on poll timeout; cleared at next accepted start
s_data  in  32  message word, first word -> BLOCK0 (bits 511:480)
s_valid  in  1  message word valid
s_ready  out  1  message word accepted when s_valid & s_ready
s_last  in  1  marks final message word
s_last_bits  in  6  valid MSB-aligned bits in the last word, 0..32; values >32 treated as 32
m_data  out  32  digest word, DIGEST0 first (DIGEST8 first in short mode)
m_valid  out  1  digest word valid; held until m_ready
m_ready  in  1  downstream accept
m_last  out  1  marks final digest word
bus_cs  out  1  core chip select
bus_we  out  1  core write enable
bus_addr  out  8  core register address
bus_wdata  out  32  core write data
bus_rdata  in  32  core read data, valid the cycle after a read (cs & !we)

Behaviour:
Reset:
- All outputs 0, state IDLE, counters 0.
- Reset mid-job abandons the job without a done pulse.
- The core must be reset by the same rst.

Bus rules:
- At most one access per cycle.
- Writes complete in the issue cycle.
- A read issued in cycle N is sampled from bus_rdata in N+1, during which bus_cs=0.
- Register map: CTRL 0x08 {short,final,update,init}, STATUS 0x09 {valid,ready}, BLOCK_BITS 0x0a, BLOCKi 0x10+i, DIGESTi 0x20+i.

FSM:
- IDLE: s_ready=0. On start, latch short_mode, clear error, set busy -> CLR.
- CLR: write CTRL={short,000}. Clears stale ctrl bits so the next set produces a rising edge. -> POLL(ready) -> INIT.
- INIT: write CTRL={short,001}, next cycle write CTRL={short,000} -> LOAD.
- LOAD:
  - s_ready=1. Each accepted word k (0..15) is written to BLOCKk in the same cycle.
  - Word index wraps at 16.
  - On word 15 without s_last, or on s_last at k<15 -> BITS.
  - When s_last arrives at k<15, the words k+1..15 are first written as 0, one per cycle, with s_ready=0 (PAD).
- BITS: write BLOCK_BITS.
  - Value is 512 for a full non-last block; 32*k+s_last_bits for the last block (0..512).
  - -> POLL(ready) -> KICK.
- KICK: write CTRL with the update bit (non-last block) or the final bit (last block), then CTRL={short,000} next cycle.
  - Non-last: -> LOAD.
  - Last: -> POLL(valid) -> RDIG.
- Last word completes exactly 512 bits: that block is treated as last (final with bits=512). No extra empty block is sent.
- Empty message: a single word with s_last and s_last_bits=0. Block is all zeros, BLOCK_BITS=0, final.
- POLL(bit): read STATUS, check the bit on the next cycle, repeat until set.
  - The poll counter counts cycles and resets on entering POLL.
  - Counter reaching POLL_LIMIT: error=1 -> ABORT.
- ABORT: write CTRL=0, pulse done, -> IDLE.
- RDIG: for each of 16 words (8 in short mode, DIGEST8..15):
  - Issue read, capture the word into m_data, assert m_valid.
  - Hold until m_ready, then issue the next read.
  - m_last=1 with the final word.
  - After the last handshake: done pulse, busy=0 -> IDLE.
- start while busy is ignored. s_valid outside LOAD is not consumed. m_ready outside RDIG is ignored.

Decomposition:
- Package streebog_bus_pkg: register addresses, CTRL/STATUS bit positions, FSM state enum, block word count (16).
- One sub-module, streebog_status_poller: issues STATUS reads, compares the selected bit, owns the POLL_LIMIT counter, returns hit/timeout.

Test Plan:
- Empty message, short_mode=0 against the streebog register core -> BLOCK_BITS write = 0, one final, 16 digest words matching the C model for the empty message; done pulses once.
- GOST R 34.11-2012 example 1 (63 bytes, 16 words, s_last_bits=24) -> BLOCK_BITS=504, PAD writes none, digest equals the standard 512-bit vector; rerun with short_mode=1 -> 8 words equal to the standard 256-bit vector.
- 1024-bit message (32 words) with random s_valid gaps and random m_ready backpressure -> exactly one update then one final with BITS=512, CTRL bits always cleared between sets, digest matches the model.
- 3-word message, s_last_bits=8 -> BLOCK3..15 written 0 on consecutive cycles with s_ready=0, BLOCK_BITS=72.
- Bus model never asserts ready, POLL_LIMIT=16 -> error=1 with done after 16 poll cycles, CTRL written 0, busy drops, next start clears error.
- rst asserted during LOAD word 7 -> next cycle all outputs 0, no done; a following full job completes correctly.

Source files
------------

// File: rtl/streebog_bus_pkg.sv
// Shared definitions for the Streebog register-port bus driver: register map,
// CTRL/STATUS bit positions, FSM state encoding and bus request payload.
package streebog_bus_pkg;

  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned BLOCK_WORDS = 16;
  localparam int unsigned IDX_W       = 4;
  localparam int unsigned BITS_W      = 10;

  localparam logic [ADDR_W-1:0] ADDR_CTRL       = 8'h08;
  localparam logic [ADDR_W-1:0] ADDR_STATUS     = 8'h09;
  localparam logic [ADDR_W-1:0] ADDR_BLOCK_BITS = 8'h0a;
  localparam logic [ADDR_W-1:0] ADDR_BLOCK0     = 8'h10;
  localparam logic [ADDR_W-1:0] ADDR_DIGEST0    = 8'h20;

  localparam int unsigned CTRL_INIT   = 0;
  localparam int unsigned CTRL_UPDATE = 1;
  localparam int unsigned CTRL_FINAL  = 2;
  localparam int unsigned CTRL_SHORT  = 3;

  localparam int unsigned STATUS_READY = 0;
  localparam int unsigned STATUS_VALID = 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BLOCK_WORDS - 1);
  localparam logic [IDX_W-1:0]  SHORT_IDX = IDX_W'(BLOCK_WORDS / 2);
  localparam logic [BITS_W-1:0] BITS_FULL = BITS_W'(BLOCK_WORDS * DATA_W);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_POLL_INIT,
    S_INIT_SET,
    S_INIT_CLR,
    S_LOAD,
    S_PAD,
    S_BITS,
    S_POLL_KICK,
    S_KICK_SET,
    S_KICK_CLR,
    S_POLL_DIG,
    S_RD,
    S_CAP,
    S_HOLD,
    S_ABORT
  } state_t;

  typedef struct packed {
    logic              cs;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  function automatic bus_req_t bus_wr(input logic [ADDR_W-1:0] addr,
                                      input logic [DATA_W-1:0] data);
    bus_req_t r;
    r.cs    = 1'b1;
    r.we    = 1'b1;
    r.addr  = addr;
    r.wdata = data;
    return r;
  endfunction

  function automatic bus_req_t bus_rd(input logic [ADDR_W-1:0] addr);
    bus_req_t r;
    r.cs    = 1'b1;
    r.we    = 1'b0;
    r.addr  = addr;
    r.wdata = '0;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] ctrl_word(input logic short_m, input logic fin,
                                                  input logic upd, input logic ini);
    logic [DATA_W-1:0] w;
    w              = '0;
    w[CTRL_SHORT]  = short_m;
    w[CTRL_FINAL]  = fin;
    w[CTRL_UPDATE] = upd;
    w[CTRL_INIT]   = ini;
    return w;
  endfunction

endpackage

// File: rtl/streebog_status_poller.sv
// STATUS polling engine: alternates read / check cycles while active and
// flags a hit on the selected bit or a timeout after POLL_LIMIT cycles.
module streebog_status_poller
  import streebog_bus_pkg::*;
#(
  parameter int unsigned POLL_LIMIT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       active,
  input  logic       bit_sel,
  input  logic [1:0] status,
  output logic       rd_c,
  output logic       hit_c,
  output logic       timeout_c
);

  localparam int unsigned CNT_W = $clog2(POLL_LIMIT + 1);

  logic             phase_q;
  logic [CNT_W-1:0] cnt_q;

  // Phase and cycle counter restart whenever the driver is not polling.
  always_ff @(posedge clk) begin
    if (rst || !active) begin
      phase_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      phase_q <= ~phase_q;
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  // Read on even cycles, test the returned bit on odd cycles.
  always_comb begin
    rd_c      = active && !phase_q;
    hit_c     = active && phase_q &&
                (bit_sel ? status[STATUS_VALID] : status[STATUS_READY]);
    timeout_c = active && !hit_c && (cnt_q == CNT_W'(POLL_LIMIT - 1));
  end

endmodule

// File: rtl/streebog_bus_driver.sv
// Bus initiator for the Streebog register core: streams message words into
// BLOCK registers, sequences INIT/UPDATE/FINAL and streams the digest out.
module streebog_bus_driver
  import streebog_bus_pkg::*;
#(
  parameter int unsigned POLL_LIMIT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        short_mode,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_last,
  input  logic [5:0]  s_last_bits,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        bus_cs,
  output logic        bus_we,
  output logic [7:0]  bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  state_t              state_q, state_d;
  logic                short_q, short_d;
  logic                last_q, last_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BITS_W-1:0]   bits_q, bits_d;
  logic                busy_d, done_d, error_d;
  logic [DATA_W-1:0]   m_data_d;
  logic                m_valid_d, m_last_d;
  logic [5:0]          last_bits_c;
  bus_req_t            req_c;
  logic                poll_active_c, poll_sel_c;
  logic                poll_rd_c, poll_hit_c, poll_timeout_c;

  assign poll_active_c = (state_q == S_POLL_INIT) || (state_q == S_POLL_KICK) ||
                         (state_q == S_POLL_DIG);
  assign poll_sel_c    = (state_q == S_POLL_DIG);
  assign last_bits_c   = (s_last_bits > 6'd32) ? 6'd32 : s_last_bits;

  streebog_status_poller #(
    .POLL_LIMIT (POLL_LIMIT)
  ) u_poller (
    .clk       (clk),
    .rst       (rst),
    .active    (poll_active_c),
    .bit_sel   (poll_sel_c),
    .status    (bus_rdata[1:0]),
    .rd_c      (poll_rd_c),
    .hit_c     (poll_hit_c),
    .timeout_c (poll_timeout_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Job context and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      short_q <= 1'b0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      bits_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      short_q <= short_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      bits_q  <= bits_d;
      busy    <= busy_d;
      done    <= done_d;
      error   <= error_d;
      m_data  <= m_data_d;
      m_valid <= m_valid_d;
      m_last  <= m_last_d;
    end
  end

  // Next-state, bus request and output decode.
  always_comb begin
    state_d   = state_q;
    short_d   = short_q;
    last_d    = last_q;
    idx_d     = idx_q;
    bits_d    = bits_q;
    busy_d    = busy;
    done_d    = 1'b0;
    error_d   = error;
    m_data_d  = m_data;
    m_valid_d = m_valid;
    m_last_d  = m_last;
    req_c     = '0;
    s_ready   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          short_d = short_mode;
          last_d  = 1'b0;
          idx_d   = '0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        req_c   = bus_wr(ADDR_CTRL, ctrl_word(short_q, 1'b0, 1'b0, 1'b0));
        state_d = S_POLL_INIT;
      end
      S_POLL_INIT, S_POLL_KICK, S_POLL_DIG: begin
        if (poll_rd_c) req_c = bus_rd(ADDR_STATUS);
        if (poll_hit_c) begin
          if (state_q == S_POLL_INIT) begin
            state_d = S_INIT_SET;
          end else if (state_q == S_POLL_KICK) begin
            state_d = S_KICK_SET;
          end else begin
            idx_d   = short_q ? SHORT_IDX : '0;
            state_d = S_RD;
          end
        end else if (poll_timeout_c) begin
          state_d = S_ABORT;
        end
      end
      S_INIT_SET: begin
        req_c   = bus_wr(ADDR_CTRL, ctrl_word(short_q, 1'b0, 1'b0, 1'b1));
        state_d = S_INIT_CLR;
      end
      S_INIT_CLR: begin
        req_c   = bus_wr(ADDR_CTRL, ctrl_word(short_q, 1'b0, 1'b0, 1'b0));
        state_d = S_LOAD;
      end
      S_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          req_c = bus_wr(ADDR_BLOCK0 + ADDR_W'(idx_q), s_data);
          idx_d = idx_q + IDX_W'(1);
          if (s_last) begin
            last_d  = 1'b1;
            bits_d  = BITS_W'({idx_q, 5'b00000}) + BITS_W'(last_bits_c);
            state_d = (idx_q == LAST_IDX) ? S_BITS : S_PAD;
          end else if (idx_q == LAST_IDX) begin
            last_d  = 1'b0;
            bits_d  = BITS_FULL;
            state_d = S_BITS;
          end
        end
      end
      S_PAD: begin
        req_c = bus_wr(ADDR_BLOCK0 + ADDR_W'(idx_q), '0);
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) state_d = S_BITS;
      end
      S_BITS: begin
        req_c   = bus_wr(ADDR_BLOCK_BITS, DATA_W'(bits_q));
        state_d = S_POLL_KICK;
      end
      S_KICK_SET: begin
        req_c   = bus_wr(ADDR_CTRL, ctrl_word(short_q, last_q, !last_q, 1'b0));
        state_d = S_KICK_CLR;
      end
      S_KICK_CLR: begin
        req_c   = bus_wr(ADDR_CTRL, ctrl_word(short_q, 1'b0, 1'b0, 1'b0));
        state_d = last_q ? S_POLL_DIG : S_LOAD;
      end
      S_RD: begin
        req_c   = bus_rd(ADDR_DIGEST0 + ADDR_W'(idx_q));
        state_d = S_CAP;
      end
      S_CAP: begin
        m_data_d  = bus_rdata;
        m_valid_d = 1'b1;
        m_last_d  = (idx_q == LAST_IDX);
        state_d   = S_HOLD;
      end
      S_HOLD: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_RD;
          end
        end
      end
      S_ABORT: begin
        req_c   = bus_wr(ADDR_CTRL, '0);
        idx_d   = '0;
        done_d  = 1'b1;
        error_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus_cs    = req_c.cs;
  assign bus_we    = req_c.we;
  assign bus_addr  = req_c.addr;
  assign bus_wdata = req_c.wdata;

endmodule

// File: tb/tb_streebog_bus_driver.sv
// Directed bench for streebog_bus_driver with a behavioural register-core model.
`timescale 1ns/1ps
module tb_streebog_bus_driver;

  localparam int unsigned POLL_LIMIT = 16;

  logic        clk = 1'b0;
  logic        rst, start, short_mode, busy, done, error;
  logic [31:0] s_data;
  logic        s_valid, s_ready, s_last;
  logic [5:0]  s_last_bits;
  logic [31:0] m_data;
  logic        m_valid, m_ready, m_last;
  logic        bus_cs, bus_we;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;

  int checks = 0;
  int errors = 0;

  // Core model state and transaction log
  logic        ready_en, clr_log, valid_flag;
  logic [31:0] rdata_q, ctrl_prev, ctrl_last, fin_word, bits_first, bits_log;
  logic [31:0] blk [16];
  int cyc = 0;
  int upd_cnt = 0, fin_cnt = 0, init_cnt = 0, ctrl_viol = 0;
  int bits_wr_cnt = 0, blk_wr_cnt = 0, pad_zero_cnt = 0, status_rd_cnt = 0;
  int done_cnt = 0, pad_first = -1, pad_last = -1;

  streebog_bus_driver #(.POLL_LIMIT(POLL_LIMIT)) dut (
    .clk(clk), .rst(rst), .start(start), .short_mode(short_mode),
    .busy(busy), .done(done), .error(error),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .s_last_bits(s_last_bits),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .bus_cs(bus_cs), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dig_word(input int i);
    return 32'hD1600000 + 32'(i) * 32'h00010101;
  endfunction

  assign bus_rdata = rdata_q;

  // Register core: logs writes, answers STATUS and DIGEST reads one cycle later
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rdata_q <= '0;
    if (done) done_cnt <= done_cnt + 1;
    if (rst) begin
      valid_flag <= 1'b0;
      ctrl_prev  <= '0;
    end else if (bus_cs && bus_we) begin
      if (bus_addr == 8'h08) begin
        if (bus_wdata[0] && !ctrl_prev[0]) begin
          init_cnt   <= init_cnt + 1;
          valid_flag <= 1'b0;
        end
        if (bus_wdata[1] && !ctrl_prev[1]) upd_cnt <= upd_cnt + 1;
        if (bus_wdata[2] && !ctrl_prev[2]) begin
          fin_cnt    <= fin_cnt + 1;
          fin_word   <= bus_wdata;
          valid_flag <= 1'b1;
        end
        if ((bus_wdata[2:0] != 3'b000) && (ctrl_prev[2:0] != 3'b000)) ctrl_viol <= ctrl_viol + 1;
        ctrl_prev <= bus_wdata;
        ctrl_last <= bus_wdata;
      end else if (bus_addr == 8'h0a) begin
        if (bits_wr_cnt == 0) bits_first <= bus_wdata;
        bits_log    <= bus_wdata;
        bits_wr_cnt <= bits_wr_cnt + 1;
      end else if (bus_addr[7:4] == 4'h1) begin
        blk[bus_addr[3:0]] <= bus_wdata;
        blk_wr_cnt <= blk_wr_cnt + 1;
        if (bus_wdata == 32'd0 && !s_ready) begin
          pad_zero_cnt <= pad_zero_cnt + 1;
          if (pad_first < 0) pad_first <= cyc;
          pad_last <= cyc;
        end
      end
    end else if (bus_cs) begin
      if (bus_addr == 8'h09) begin
        rdata_q       <= {30'd0, valid_flag, ready_en};
        status_rd_cnt <= status_rd_cnt + 1;
      end else if (bus_addr[7:4] == 4'h2) begin
        rdata_q <= dig_word(int'(bus_addr[3:0]));
      end
    end
    if (clr_log) begin
      upd_cnt <= 0; fin_cnt <= 0; init_cnt <= 0; ctrl_viol <= 0;
      bits_wr_cnt <= 0; blk_wr_cnt <= 0; pad_zero_cnt <= 0; status_rd_cnt <= 0;
      done_cnt <= 0; pad_first <= -1; pad_last <= -1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    clr_log = 1'b1;
    tick();
    clr_log = 1'b0;
  endtask

  task automatic start_job(input logic sm);
    start      = 1'b1;
    short_mode = sm;
    tick();
    start      = 1'b0;
    short_mode = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic [5:0] lb,
                           input int gap);
    bit ok;
    repeat (gap) tick();
    s_data = d; s_last = last; s_last_bits = lb; s_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0; s_last_bits = '0; s_data = '0;
    check("stream_accept", 32'(ok), 32'd1);
  endtask

  task automatic recv_digest(input int n, input int base, input bit bp);
    bit got;
    for (int w = 0; w < n; w++) begin
      got = 1'b0;
      m_ready = 1'b0;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        if (m_valid) begin got = 1'b1; break; end
      end
      check("digest_valid_seen", 32'(got), 32'd1);
      if (!got) return;
      if (bp) begin
        repeat ($urandom_range(3, 1)) @(negedge clk);
        check("digest_held", 32'(m_valid), 32'd1);
      end
      check($sformatf("digest_word%0d", w), m_data, dig_word(base + w));
      check($sformatf("digest_last%0d", w), 32'(m_last), 32'(w == n - 1));
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
    end
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] acc;
    logic [31:0] msg [32];
    bit got;

    rst = 1'b1; start = 1'b0; short_mode = 1'b0;
    s_data = '0; s_valid = 1'b0; s_last = 1'b0; s_last_bits = '0;
    m_ready = 1'b0; ready_en = 1'b1; clr_log = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_bus_cs", 32'(bus_cs), 32'd0);
    check("rst_m_data", m_data, 32'd0);

    // Empty message, 512-bit digest
    clear_log();
    start_job(1'b0);
    check("t1_busy", 32'(busy), 32'd1);
    send_word(32'd0, 1'b1, 6'd0, 0);
    recv_digest(16, 0, 1'b0);
    repeat (3) tick();
    acc = '0;
    for (int i = 0; i < 16; i++) acc = acc | blk[i];
    check("t1_bits", bits_log, 32'd0);
    check("t1_bits_writes", 32'(bits_wr_cnt), 32'd1);
    check("t1_final", 32'(fin_cnt), 32'd1);
    check("t1_update", 32'(upd_cnt), 32'd0);
    check("t1_init", 32'(init_cnt), 32'd1);
    check("t1_blk_writes", 32'(blk_wr_cnt), 32'd16);
    check("t1_blk_zero", acc, 32'd0);
    check("t1_fin_word", fin_word, 32'h4);
    check("t1_ctrl_viol", 32'(ctrl_viol), 32'd0);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_error", 32'(error), 32'd0);

    // 63-byte message in 16 words, full then short digest
    for (int i = 0; i < 16; i++) msg[i] = 32'h30313233 + 32'(i) * 32'h04040404;
    for (int r = 0; r < 2; r++) begin
      clear_log();
      start_job(r == 1);
      for (int i = 0; i < 16; i++) send_word(msg[i], i == 15, (i == 15) ? 6'd24 : 6'd0, 0);
      recv_digest((r == 1) ? 8 : 16, (r == 1) ? 8 : 0, 1'b0);
      repeat (3) tick();
      check($sformatf("t2_bits_r%0d", r), bits_log, 32'd504);
      check($sformatf("t2_pad_r%0d", r), 32'(pad_zero_cnt), 32'd0);
      check($sformatf("t2_blk0_r%0d", r), blk[0], msg[0]);
      check($sformatf("t2_blk15_r%0d", r), blk[15], msg[15]);
      check($sformatf("t2_fin_word_r%0d", r), fin_word, (r == 1) ? 32'hC : 32'h4);
      check($sformatf("t2_ctrl_last_r%0d", r), ctrl_last, (r == 1) ? 32'h8 : 32'h0);
      check($sformatf("t2_done_r%0d", r), 32'(done_cnt), 32'd1);
    end

    // 1024-bit message with stream gaps and digest backpressure
    for (int i = 0; i < 32; i++) msg[i] = 32'h10000000 + 32'(i);
    clear_log();
    start_job(1'b0);
    for (int i = 0; i < 32; i++)
      send_word(msg[i], i == 31, (i == 31) ? 6'd32 : 6'd0, int'($urandom_range(2, 0)));
    recv_digest(16, 0, 1'b1);
    repeat (3) tick();
    check("t3_update", 32'(upd_cnt), 32'd1);
    check("t3_final", 32'(fin_cnt), 32'd1);
    check("t3_bits_writes", 32'(bits_wr_cnt), 32'd2);
    check("t3_bits_first", bits_first, 32'd512);
    check("t3_bits_last", bits_log, 32'd512);
    check("t3_ctrl_viol", 32'(ctrl_viol), 32'd0);
    check("t3_blk0", blk[0], msg[16]);
    check("t3_blk15", blk[15], msg[31]);
    check("t3_pad", 32'(pad_zero_cnt), 32'd0);
    check("t3_done", 32'(done_cnt), 32'd1);

    // 3-word message: BLOCK3..15 padded on consecutive cycles
    clear_log();
    start_job(1'b1);
    for (int i = 0; i < 3; i++) send_word(32'hA0000001 + 32'(i), i == 2, (i == 2) ? 6'd8 : 6'd0, 0);
    recv_digest(8, 8, 1'b0);
    repeat (3) tick();
    check("t4_bits", bits_log, 32'd72);
    check("t4_pad_cnt", 32'(pad_zero_cnt), 32'd13);
    check("t4_pad_span", 32'(pad_last - pad_first), 32'd12);
    check("t4_blk2", blk[2], 32'hA0000003);
    check("t4_blk15", blk[15], 32'd0);
    check("t4_blk_writes", 32'(blk_wr_cnt), 32'd16);

    // Core never ready: poll timeout aborts the job
    ready_en = 1'b0;
    clear_log();
    start_job(1'b0);
    wait_done(got);
    check("t5_done_seen", 32'(got), 32'd1);
    check("t5_error", 32'(error), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    check("t5_status_reads", 32'(status_rd_cnt), 32'd8);
    check("t5_ctrl_zero", ctrl_last, 32'd0);
    check("t5_done_cnt", 32'(done_cnt), 32'd1);

    // Next start clears error; reset during LOAD word 7 abandons the job
    ready_en = 1'b1;
    clear_log();
    start_job(1'b0);
    check("t6_error_clr", 32'(error), 32'd0);
    check("t6_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 7; i++) send_word(32'h77000000 + 32'(i), 1'b0, 6'd0, 0);
    s_data = 32'h77000007; s_valid = 1'b1; rst = 1'b1;
    tick();
    check("t6_busy_rst", 32'(busy), 32'd0);
    check("t6_done_rst", 32'(done), 32'd0);
    check("t6_s_ready_rst", 32'(s_ready), 32'd0);
    check("t6_m_valid_rst", 32'(m_valid), 32'd0);
    check("t6_bus_cs_rst", 32'(bus_cs), 32'd0);
    check("t6_bus_we_rst", 32'(bus_we), 32'd0);
    check("t6_bus_addr_rst", 32'(bus_addr), 32'd0);
    check("t6_bus_wdata_rst", bus_wdata, 32'd0);
    s_valid = 1'b0; s_data = '0; rst = 1'b0;
    repeat (2) tick();
    check("t6_no_done", 32'(done_cnt), 32'd0);

    // Full job after reset; s_last_bits above 32 clamps to 32
    clear_log();
    start_job(1'b0);
    send_word(32'hA5A5A5A5, 1'b1, 6'd40, 0);
    recv_digest(16, 0, 1'b0);
    repeat (3) tick();
    check("t7_bits", bits_log, 32'd32);
    check("t7_pad", 32'(pad_zero_cnt), 32'd15);
    check("t7_blk0", blk[0], 32'hA5A5A5A5);
    check("t7_done", 32'(done_cnt), 32'd1);
    check("t7_error", 32'(error), 32'd0);
    check("t7_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
